muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle RV32M execution unit that responds to the `mul_en`/`div_en` control lines produced by the control-unit decoder.
- It sits in the execute stage beside the ALU. It accepts one operation at a time, stalls the pipeline while it iterates, and returns a 32-bit result with a one-cycle `done` pulse.
- Multiply is radix-2 shift-add. Divide is radix-2 restoring.

Parameters:
XLEN, 32, operand/result width
ITER, 32, iteration count per operation (must equal XLEN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mul_en  in  1  decoder multiply request (execute-stage copy)
div_en  in  1  decoder divide request (execute-stage copy)
funct3  in  3  M-extension op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
src_a  in  XLEN  rs1 operand
src_b  in  XLEN  rs2 operand
flush  in  1  pipeline flush; aborts the current operation
stall  out  1  hold IF/ID/EX pipeline registers
busy  out  1  unit is computing
done  out  1  one-cycle pulse; result is valid this cycle
result  out  XLEN  operation result

Behaviour:
- Reset is asynchronous and active-low. While rst_n is low:
  - state = IDLE, count = 0.
  - All outputs are 0: busy, done, stall, result.
  - All datapath registers are cleared.
- start = (mul_en | div_en) & (state == IDLE) & ~flush.
  - If mul_en and div_en are both high, mul_en wins.
  - funct3 selects the op within the selected class. Only funct3[1:0] is used for mul; funct3[1:0] is used with the div/rem split for div.
- States and transitions:
  - IDLE:
    - On start, latch operands, op and sign info.
    - If the op is a special-case divide, go to DONE. Otherwise go to BUSY with count = 0.
  - BUSY: perform one iteration per cycle, count++. After the iteration with count == ITER-1, go to DONE.
  - DONE: done = 1 and result valid for exactly one cycle, then IDLE.
- Latency:
  - start sampled at edge N.
  - Normal ops: done high during the cycle after edge N+ITER+1, i.e. 33 cycles after start for XLEN = 32.
  - Special cases: done high after edge N+1.
- Stall timing:
  - stall = (state == BUSY) | start. The stall is combinational, so the start cycle itself stalls.
  - stall is low in DONE, so the pipeline advances and captures result that cycle.
- busy = (state == BUSY).
- Request acceptance:
  - Requests while in BUSY or DONE are ignored, not queued.
  - A request on the cycle after DONE is accepted normally (back-to-back operations).
- Multiply:
  - Operands are sign-handled by op. MUL/MULH: both signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
  - Magnitudes are multiplied over 64 bits; the product is negated if signs differ.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Magnitude restoring division.
  - Quotient is negated if the signs of a and b differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases (no iteration, go straight to DONE):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return src_a.
  - Signed overflow (src_a = 0x80000000, src_b = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Flush:
  - flush in BUSY or DONE returns to IDLE at the next edge.
  - No done pulse; result is held at its previous value.
  - flush in IDLE blocks start.
- result holds its last value between operations. It is only updated on entry to DONE.
- Asynchronous reset mid-operation: immediate IDLE, no done pulse, all outputs 0.

Decomposition:
- muldiv_pkg holds:
  - funct3 op localparams (OP_MUL … OP_REMU).
  - typedef enum logic [1:0] state_t {IDLE, BUSY, DONE}.
  - XLEN default.
- Sub-module div_step:
  - Combinational, one restoring-division iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
  - Reused so a later radix-4 variant can instantiate it twice.

Test Plan:
- MUL: src_a = 7, src_b = 0xFFFFFFFD (-3), mul_en → stall high on the start cycle; busy for 32 cycles; done 33 cycles after start with result 0xFFFFFFEB.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU with a = 0xFFFFFFFF, b = 2 → 0xFFFFFFFF.
- DIV: 100 / 0xFFFFFFF9 (-7) → 0xFFFFFFF2. REM same operands → 2. DIVU: 100 / 7 → 14. REMU → 2.
- Special cases, all with done one cycle after start and busy never asserted:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Flush and reset mid-operation:
  - Assert flush 10 cycles into a DIV → IDLE next edge; no done; stall low; result unchanged.
  - A new MUL issued immediately after completes correctly.
  - Drop rst_n mid-MUL → outputs 0 asynchronously.
- Back-to-back and ignored requests:
  - MUL, then DIV requested the cycle after DONE → both results correct, second done 33 cycles later.
  - mul_en held high throughout BUSY does not restart the operation.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
package muldiv_pkg;
    localparam int XLEN_DEF = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/muldiv_unit_div_step.sv
// One radix-2 restoring-division iteration (combinational).
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_i < dvsr_i, so the top bit of diff is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, dvsr_i};
        if (diff[XLEN]) begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: radix-2 shift-add multiply, restoring divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_en,
    input  logic            div_en,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic                is_div_q, is_div_d;
    logic                is_rem_q, is_rem_d;
    logic                hi_q, hi_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     dvsr_q, dvsr_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic              start, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special, rem_nx, quo_nx, quo_s, rem_s, fin;
    logic [2*XLEN-1:0] acc_nx, prod;
    logic              f3_unused;

    assign f3_unused = funct3[2];

    // rst_n gates start so stall stays low while the unit is held in reset.
    assign start = (mul_en | div_en) & (state_q == IDLE) & ~flush & rst_n;

    assign a_sgn    = mul_en ? (funct3[1:0] != OP_MULHU[1:0]) : ~funct3[0];
    assign b_sgn    = mul_en ? ~funct3[1] : ~funct3[0];
    assign a_neg    = a_sgn & src_a[XLEN-1];
    assign b_neg    = b_sgn & src_b[XLEN-1];
    assign a_mag    = a_neg ? -src_a : src_a;
    assign b_mag    = b_neg ? -src_b : src_b;
    assign div_zero = (src_b == '0);
    assign div_ovf  = ~funct3[0] & (src_a == MIN_NEG) & (src_b == ALL_ONES);
    assign special  = div_zero ? (funct3[1] ? src_a : ALL_ONES)
                               : (funct3[1] ? '0 : MIN_NEG);

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (rem_nx),
        .quo_o  (quo_nx)
    );

    // Final value is formed from the last iteration's combinational output.
    assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod   = neg_q ? -acc_nx : acc_nx;
    assign quo_s  = neg_q ? -quo_nx : quo_nx;
    assign rem_s  = rneg_q ? -rem_nx : rem_nx;
    assign fin    = is_div_q ? (is_rem_q ? rem_s : quo_s)
                             : (hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        is_rem_d = is_rem_q;
        hi_d     = hi_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (start) begin
                    is_div_d = ~mul_en;
                    is_rem_d = funct3[1];
                    hi_d     = (funct3[1:0] != OP_MUL[1:0]);
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    acc_d    = '0;
                    mcand_d  = {{XLEN{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    rem_d    = '0;
                    quo_d    = a_mag;
                    dvsr_d   = b_mag;
                    if (~mul_en & (div_zero | div_ovf)) begin
                        result_d = special;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = acc_nx;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    rem_d    = rem_nx;
                    quo_d    = quo_nx;
                    count_d  = count_q + CW'(1);
                    if (count_q == CW'(ITER-1)) begin
                        result_d = fin;
                        state_d  = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            hi_q     <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            is_rem_q <= is_rem_d;
            hi_q     <= hi_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == BUSY);
    assign done   = (state_q == DONE);
    assign stall  = busy | start;
    assign result = result_q;
endmodule
